// File: rtl/spi_xfer_pkg.sv
// rtl/spi_xfer_pkg.sv - shared types, width helper and idle levels for spi_xfer_master
package spi_xfer_pkg;

   // Transfer sequencer states
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_HIGH  = 3'd2,
      S_LOW   = 3'd3,
      S_HOLD  = 3'd4,
      S_DONE  = 3'd5
   } spi_xfer_state_e;

   // Levels driven on the serial lines when no bit is being shifted
   localparam logic SCK_IDLE  = 1'b0;
   localparam logic MOSI_IDLE = 1'b0;

   // Width of a bit count that must be able to hold max_bits itself
   function automatic int len_w(input int max_bits);
      return $clog2(max_bits + 1);
   endfunction

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - half-period counter, ticks on the last cycle of each state
module spi_clk_div #(
   parameter int CLK_DIV = 2
) (
   input  logic clock,
   input  logic reset_n,
   input  logic load,
   output logic tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

   logic [CW-1:0] count;

   // Reload on every state entry, then count down and park at zero
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= RELOAD;
      end else if (load) begin
         count <= RELOAD;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign tick = (count == '0);

endmodule

// File: rtl/spi_xfer_master.sv
// rtl/spi_xfer_master.sv - single-slave SPI master; SPI_XFER_LSB_FIRST_EN adds req_lsb
module spi_xfer_master
   import spi_xfer_pkg::*;
#(
   parameter  int CLK_DIV  = 2,
   parameter  int MAX_BITS = 16,
   localparam int LW       = len_w(MAX_BITS)
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [LW-1:0]       req_len,
   input  logic [MAX_BITS-1:0] req_data,
`ifdef SPI_XFER_LSB_FIRST_EN
   input  logic                req_lsb,
`endif
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [MAX_BITS-1:0] rsp_data,
   output logic                ss,
   output logic                sck,
   output logic                mosi,
   input  logic                miso
);

   localparam logic [LW-1:0] MAX_L = LW'(MAX_BITS);

   spi_xfer_state_e     state;
   logic [LW-1:0]       len_q;
   logic [LW-1:0]       bit_cnt;
   logic [LW-1:0]       cnt_nxt;
   logic [LW-1:0]       len_c;
   logic [MAX_BITS-1:0] tx_sh;
   logic [MAX_BITS-1:0] rx_sh;
   logic                lsb_q;
   logic                tick;
   logic                load;
   logic                busy;
   logic                shifting;

   assign len_c   = (req_len > MAX_L) ? MAX_L : req_len;
   assign cnt_nxt = bit_cnt + 1'b1;

   // Counter restarts on every state change; IDLE keeps it primed for SETUP
   assign load = (state == S_IDLE) || tick;

   spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
      .clock   (clock),
      .reset_n (reset_n),
      .load    (load),
      .tick    (tick)
   );

`ifdef SPI_XFER_LSB_FIRST_EN
   // Bit order is fixed for the whole transfer at request time
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lsb_q <= 1'b0;
      end else if (state == S_IDLE && req_valid) begin
         lsb_q <= req_lsb;
      end
   end
`else
   assign lsb_q = 1'b0;
`endif

   // Sequencer plus transmit/receive shift registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         len_q   <= '0;
         bit_cnt <= '0;
         tx_sh   <= '0;
         rx_sh   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  // MSB-first data is left-aligned so the first bit sits at the top
                  `ifdef SPI_XFER_LSB_FIRST_EN
                  tx_sh <= req_lsb ? req_data : (req_data << (MAX_L - len_c));
                  `else
                  tx_sh <= req_data << (MAX_L - len_c);
                  `endif
                  rx_sh   <= '0;
                  bit_cnt <= '0;
                  len_q   <= len_c;
                  state   <= (len_c == '0) ? S_DONE : S_SETUP;
               end
            end
            S_SETUP: begin
               if (tick) state <= S_HIGH;
            end
            S_HIGH: begin
               if (tick) begin
                  // This edge is the falling edge of sck: capture, then present next bit
                  if (lsb_q) begin
                     rx_sh <= rx_sh | (MAX_BITS'(miso) << bit_cnt);
                     tx_sh <= tx_sh >> 1;
                  end else begin
                     rx_sh <= {rx_sh[MAX_BITS-2:0], miso};
                     tx_sh <= tx_sh << 1;
                  end
                  bit_cnt <= cnt_nxt;
                  state   <= (cnt_nxt == len_q) ? S_HOLD : S_LOW;
               end
            end
            S_LOW: begin
               if (tick) state <= S_HIGH;
            end
            S_HOLD: begin
               if (tick) state <= S_DONE;
            end
            S_DONE: begin
               if (rsp_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Line levels and handshakes are pure functions of the state
   always_comb begin
      busy      = (state == S_SETUP) || (state == S_HIGH) ||
                  (state == S_LOW)   || (state == S_HOLD);
      shifting  = (state == S_SETUP) || (state == S_HIGH) || (state == S_LOW);
      ss        = !busy;
      sck       = (state == S_HIGH) ? 1'b1 : SCK_IDLE;
      mosi      = shifting ? (lsb_q ? tx_sh[0] : tx_sh[MAX_BITS-1]) : MOSI_IDLE;
      req_ready = (state == S_IDLE);
      rsp_valid = (state == S_DONE);
      rsp_data  = rx_sh;
   end

endmodule

// File: tb/tb_spi_xfer_master.sv
// tb/tb_spi_xfer_master.sv - table-driven scoreboard bench for spi_xfer_master
module tb_spi_xfer_master;

   localparam int CD = 2;
   localparam int MB = 16;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [4:0]  req_len = '0;
   logic [15:0] req_data = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [15:0] rsp_data;
   logic        ss, sck, mosi, miso;
`ifdef SPI_XFER_LSB_FIRST_EN
   logic        req_lsb = 1'b0;
`endif

   spi_xfer_master #(.CLK_DIV(CD), .MAX_BITS(MB)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_len   (req_len),
      .req_data  (req_data),
`ifdef SPI_XFER_LSB_FIRST_EN
      .req_lsb   (req_lsb),
`endif
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .ss        (ss),
      .sck       (sck),
      .mosi      (mosi),
      .miso      (miso)
   );

   always #5 clock = ~clock;

   // miso source: 0 tied low, 1 tied high, 2 bitrev slave, 3 loopback of mosi
   int         mode = 0;
   int         br_cnt = 0;
   logic [7:0] br_sh = '0;
   logic       br_miso;

   always @(posedge sck or posedge ss) begin
      if (ss) begin
         br_cnt = 0;
         br_sh  = '0;
      end else begin
         if (br_cnt < 8) br_sh = {br_sh[6:0], mosi};
         br_cnt++;
      end
   end

   assign br_miso = (br_cnt >= 9 && br_cnt <= 16) ? br_sh[16 - br_cnt] : 1'b1;
   assign miso = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : (mode == 2) ? br_miso : mosi;

   // Line monitors
   int   rises = 0;
   int   ss_low = 0;
   logic mosi_q[$];

   always @(posedge sck) begin
      rises++;
      mosi_q.push_back(mosi);
   end

   always @(negedge clock) if (ss === 1'b0) ss_low++;

   int          tests = 0;
   int          fails = 0;
   logic [15:0] sb[$];

   task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [4:0]  len;
      logic [15:0] data;
      int          mode;
      logic [15:0] exp;
      int          hold;
   } vec_t;

   vec_t vecs[10];

   task automatic clear_mon();
      rises  = 0;
      ss_low = 0;
      mosi_q.delete();
   endtask

   task automatic xfer(input vec_t v);
      int   n;
      int   lc;
      int   exp_ss;
      bit   ok;
      int   bad;
      logic [15:0] d;
      logic [15:0] hold_v;
      logic [15:0] e;
      lc     = (v.len > 5'd16) ? 16 : int'(v.len);
      exp_ss = (lc == 0) ? 0 : CD * (2 * lc + 1);
      d      = v.data;
      @(negedge clock);
      mode = v.mode;
      clear_mon();
      req_valid = 1'b1;
      req_len   = v.len;
      req_data  = v.data;
      n = 0;
      while (!req_ready && n < 100) begin @(negedge clock); n++; end
      check("accept", req_ready === 1'b1, 32'(req_ready), 32'd1);
      @(posedge clock);
      sb.push_back(v.exp);
      #1 req_valid = 1'b0;
      n = 1;
      @(negedge clock);
      while (rsp_valid !== 1'b1 && n < 2000) begin @(negedge clock); n++; end
      if (lc == 0)
         check("len0 latency", rsp_valid === 1'b1 && n <= 2, 32'(n), 32'd2);
      else
         check("rsp latency", rsp_valid === 1'b1 && n == exp_ss + 1, 32'(n), 32'(exp_ss + 1));
      check("ss low cycles", ss_low == exp_ss, 32'(ss_low), 32'(exp_ss));
      check("sck rises", rises == lc, 32'(rises), 32'(lc));
      bad = -1;
      for (int i = 0; i < lc; i++)
         if (i >= mosi_q.size() || mosi_q[i] !== d[lc-1-i]) begin
            if (bad < 0) bad = i;
         end
      check("mosi order", bad < 0, 32'(bad), 32'hFFFFFFFF);
      if (v.hold > 0) begin
         hold_v = rsp_data;
         ok = 1'b1;
         for (int i = 0; i < v.hold; i++) begin
            @(negedge clock);
            if (rsp_valid !== 1'b1 || rsp_data !== hold_v || req_ready !== 1'b0) ok = 1'b0;
         end
         check("hold stable", ok, 32'(rsp_data), 32'(hold_v));
      end
      rsp_ready = 1'b1;
      if (sb.size() == 0) begin
         check("scoreboard empty", 1'b0, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check("rsp_data", rsp_valid === 1'b1 && rsp_data === e, 32'(rsp_data), 32'(e));
      end
      @(posedge clock);
      #1 rsp_ready = 1'b0;
      @(negedge clock);
      check("req_ready after rsp", req_ready === 1'b1 && rsp_valid === 1'b0,
            {30'd0, rsp_valid, req_ready}, 32'd1);
   endtask

   initial begin
      int  n;
      bit  ok;
      vec_t v;
      vecs[0] = '{5'd8,  16'h00A5, 0, 16'h0000, 10};
      vecs[1] = '{5'd16, 16'hA500, 2, 16'hFFA5, 0};
      vecs[2] = '{5'd4,  16'h0009, 3, 16'h0009, 0};
      vecs[3] = '{5'd1,  16'h0001, 1, 16'h0001, 0};
      vecs[4] = '{5'd16, 16'h1234, 3, 16'h1234, 0};
      vecs[5] = '{5'd0,  16'hFFFF, 3, 16'h0000, 0};
      vecs[6] = '{5'd31, 16'hABCD, 3, 16'hABCD, 0};
      vecs[7] = '{5'd5,  16'hFFFF, 1, 16'h001F, 0};
      vecs[8] = '{5'd12, 16'h0F0F, 3, 16'h0F0F, 0};
      vecs[9] = '{5'd3,  16'hFFF5, 3, 16'h0005, 0};

      // Reset and idle
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check("reset ss", ss === 1'b1, 32'(ss), 32'd1);
      check("reset sck", sck === 1'b0, 32'(sck), 32'd0);
      check("reset req_ready", req_ready === 1'b1, 32'(req_ready), 32'd1);
      check("reset rsp_valid", rsp_valid === 1'b0, 32'(rsp_valid), 32'd0);
      check("reset rsp_data", rsp_data === 16'h0, 32'(rsp_data), 32'd0);
      clear_mon();
      repeat (100) @(negedge clock);
      check("idle no sck", rises == 0 && ss_low == 0, 32'(rises), 32'd0);

      for (int i = 0; i < 10; i++) xfer(vecs[i]);

      // Reset in the middle of a len=8 transfer
      @(negedge clock);
      mode = 1;
      clear_mon();
      req_valid = 1'b1;
      req_len   = 5'd8;
      req_data  = 16'h00A5;
      @(posedge clock);
      #1 req_valid = 1'b0;
      n = 0;
      while (rises < 3 && n < 500) begin @(negedge clock); n++; end
      check("abort reached 3 rises", rises == 3, 32'(rises), 32'd3);
      reset_n = 1'b0;
      #1;
      check("abort ss", ss === 1'b1, 32'(ss), 32'd1);
      check("abort sck", sck === 1'b0, 32'(sck), 32'd0);
      check("abort rsp_valid", rsp_valid === 1'b0, 32'(rsp_valid), 32'd0);
      check("abort mosi", mosi === 1'b0, 32'(mosi), 32'd0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      clear_mon();
      ok = 1'b1;
      repeat (50) begin
         @(negedge clock);
         if (rsp_valid !== 1'b0 || req_ready !== 1'b1) ok = 1'b0;
      end
      check("no rsp after abort", ok && ss_low == 0, 32'(rsp_valid), 32'd0);
      v = '{5'd4, 16'h0009, 3, 16'h0009, 0};
      xfer(v);

      check("scoreboard drained", sb.size() == 0, 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/spi_xfer_master.md
# spi_xfer_master

Single-slave SPI master that turns one command (bit length plus transmit data) into a framed SPI transfer on `ss`/`sck`/`mosi` and returns the bits captured on `miso`. It sits directly upstream of the SPI slave peripherals on the NPC peripheral bus, including the `bitrev` test slave. It is driven by a valid/ready request port and answers on a valid/ready response port. Transfers are serialized: one transfer is in flight at a time.

## Interface
- `CLK_DIV`, default 2: `clock` cycles per `sck` half-period; legal range ≥1.
- `MAX_BITS`, default 16: maximum transfer length and data width.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  reset; asynchronous assert, active-low.
- `req_valid`  in  1  command valid.
- `req_ready`  out  1  command accepted when high with `req_valid`.
- `req_len`  in  $clog2(MAX_BITS+1)  bit count.
- `req_data`  in  MAX_BITS  transmit data, right-aligned.
- `rsp_valid`  out  1  result valid; held until `rsp_ready`.
- `rsp_ready`  in  1  result consumed.
- `rsp_data`  out  MAX_BITS  received bits, right-aligned, upper bits zero.
- `ss`  out  1  slave select, active-low.
- `sck`  out  1  serial clock; idle low.
- `mosi`  out  1  master out.
- `miso`  in  1  slave out.

## Operation
- States: IDLE, SETUP, HIGH, LOW, HOLD, DONE.
- IDLE: `ss`=1, `sck`=0, `req_ready`=1 (combinational, `state==IDLE`). On handshake:
  - latch `req_data`;
  - latch `len` as `req_len` clamped to MAX_BITS;
  - clear the bit counter and receive shift register.
- `len==0`: go straight to DONE, `rsp_data`=0, `ss` never asserted.
- SETUP: `ss`=0, `mosi` = first bit, `sck`=0, for CLK_DIV cycles, then HIGH.
- HIGH: `sck`=1 for CLK_DIV cycles. On the last cycle, sample `miso` into the receive register and increment the bit count. If count==len, go to HOLD; otherwise go to LOW.
- LOW: `sck`=0. On entry `mosi` presents the next bit. After CLK_DIV cycles, go to HIGH.
- HOLD: `sck`=0, `ss`=0 for CLK_DIV cycles, then DONE.
- DONE: `ss`=1, `rsp_valid`=1, `rsp_data` stable. On `rsp_ready`, go to IDLE.
- Bit order: MSB-first. Transmit `req_data[len-1]` down to `[0]`; received bits shift in at the LSB.
- `mosi` changes only while `sck` is low. `miso` is sampled at the falling edge of `sck`, so slaves that update `miso` on the rising edge are supported.
- `mosi` is 0 outside SETUP/HIGH/LOW.
- Reset (any state, including mid-transfer): `ss`=1, `sck`=0, `mosi`=0, `rsp_valid`=0, `rsp_data`=0, state IDLE, so `req_ready`=1 after reset. A partial transfer is discarded and produces no response.

## Timing
- Handshake cycle N → SETUP from N+1, `ss` low from N+1.
- `ss` low for CLK_DIV·(2·len+1) cycles. `rsp_valid` rises in the cycle `ss` returns high.
- `sck` period is 2·CLK_DIV; exactly len rising edges per transfer.
- `req_ready` returns the cycle after the `rsp` handshake. No request is accepted in the same cycle as a response handshake. Minimum `ss`-high gap between transfers is 2 cycles.
- `req_*` inputs are ignored outside IDLE. `rsp_ready` is ignored outside DONE.

## Configuration
- `SPI_XFER_LSB_FIRST_EN` defined: adds input `req_lsb` (1 bit), latched at request.
  - When `req_lsb`=1, transmit `req_data[0]` first and store received bit i at `rsp_data[i]`.
  - When `req_lsb`=0, behaviour is as MSB-first.
- Macro undefined: port absent; MSB-first only.

## Structure
- `spi_xfer_pkg` holds:
  - state enum `spi_xfer_state_e`;
  - `LEN_W` width helper;
  - idle levels for `sck`/`mosi`.
- Sub-module `spi_clk_div`: half-period counter. Loads CLK_DIV-1 on state entry and asserts `tick` at zero. All state durations derive from `tick`.
- Data path uses separate transmit and receive shift registers in the top module.

## Test plan
- Reset then idle: `ss`=1, `sck`=0, `req_ready`=1, `rsp_valid`=0, and no `sck` edges for 100 cycles.
- len=8, data=8'hA5, CLK_DIV=2, `miso` tied 0:
  - `mosi` at each `sck` rise is 1,0,1,0,0,1,0,1;
  - `ss` low for exactly 34 cycles;
  - `rsp_data`=0.
- len=16, data=16'hA500, `bitrev` slave attached (echoes first byte after 8 bits, `miso`=1 during receive):
  - `rsp_data`=16'hFFA5.
- `rsp_ready` held low 10 cycles after DONE:
  - `rsp_valid`/`rsp_data` stable, `req_ready`=0;
  - `req_ready`=1 the cycle after `rsp_ready`.
- `reset_n` pulsed low after 3 `sck` rises of a len=8 transfer:
  - immediate `ss`=1, `sck`=0, `rsp_valid`=0;
  - the next len=4 data=4'h9 transfer completes normally.
- Edge lengths:
  - len=0 → `rsp_valid` 2 cycles after request, `ss` never low, `rsp_data`=0;
  - len=31 with MAX_BITS=16 → exactly 16 `sck` rises.
